// File: rtl/serial_adder.sv
// serial_adder: bit-serial a + b + cin over WIDTH cycles, LSB first, with start/done handshake
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
    logic [CW-1:0]    cnt;
    logic             carry, sum_bit, carry_nx, last;
    always_comb begin
        sum_bit  = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nx = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        sum_nx   = (sum_sh >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
        last     = cnt == CW'(WIDTH - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            s      <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nx;
                    carry  <= carry_nx;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        // carry still holds the carry into the MSB on this edge
                        s     <= sum_nx;
                        cout  <= carry_nx;
                        ovf   <= carry ^ carry_nx;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, s8;
    logic       start1, cin1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, s1;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [9:0] q8[$];
    logic [1:0] q1[$];

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
    );
    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, cout, s} from plain integer arithmetic
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] f;
        f = {1'b0, a} + {1'b0, b} + {8'd0, c};
        return {(a[7] == b[7]) && (f[7] != a[7]), f};
    endfunction

    task automatic wait_done8(output int k, output int nb);
        k = 0;
        nb = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy8) nb++;
        end while (!done8 && k < 40);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
        int k, nb;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(model8(a, b, c));
        @(posedge clk);
        #1 start8 = 1'b0;
        a8 = ~a; b8 = ~b; cin8 = ~c;
        wait_done8(k, nb);
        chk({tag, "_done"}, done8, 1);
        chk({tag, "_latency"}, k - 1, 8);
        chk({tag, "_busy_cycles"}, nb, 9);
        if (q8.size() > 0) chk({tag, "_result"}, {ovf8, cout8, s8}, q8.pop_front());
        @(negedge clk);
        chk({tag, "_done_pulse"}, done8, 0);
        chk({tag, "_idle_busy"}, busy8, 0);
    endtask

    task automatic op1(input logic a, input logic b, input logic c);
        int k, nb;
        logic [1:0] f;
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        f = {1'b0, a} + {1'b0, b} + {1'b0, c};
        q1.push_back(f);
        @(posedge clk);
        #1 start1 = 1'b0;
        a1 = ~a; b1 = ~b; cin1 = ~c;
        k = 0;
        nb = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy1) nb++;
        end while (!done1 && k < 20);
        chk("w1_done", done1, 1);
        chk("w1_latency", k - 1, 1);
        chk("w1_busy_cycles", nb, 2);
        if (q1.size() > 0) begin
            f = q1.pop_front();
            chk("w1_sum", {cout1, s1}, f);
            chk("w1_ovf", ovf1, c ^ f[1]);
        end
        @(negedge clk);
        chk("w1_done_pulse", done1, 0);
    endtask

    initial begin
        int k, nb, ndone;
        logic [7:0] last_s;
        logic [7:0] ta[4] = '{8'h11, 8'hF0, 8'h7F, 8'h05};
        logic [7:0] tb[4] = '{8'h22, 8'h20, 8'h7F, 8'hFB};
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_w8", {busy8, done8, cout8, ovf8, s8}, 0);
        chk("reset_w1", {busy1, done1, cout1, ovf1, s1}, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) op1(i[2], i[1], i[0]);

        op8("add_0f_01", 8'h0F, 8'h01, 1'b0);
        op8("add_ff_00_c", 8'hFF, 8'h00, 1'b1);
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0);
        op8("add_80_80", 8'h80, 8'h80, 1'b0);
        op8("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1);

        // start while busy is dropped
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(model8(8'd3, 8'd4, 1'b0));
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hAA; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        wait_done8(k, nb);
        chk("busy_start_done", done8, 1);
        if (q8.size() > 0) chk("busy_start_result", {ovf8, cout8, s8}, q8.pop_front());
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("busy_start_extra_done", ndone, 0);

        // back-to-back with start held high; sampling only in IDLE gives WIDTH+2 period
        @(negedge clk);
        a8 = ta[0]; b8 = tb[0]; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(model8(ta[0], tb[0], 1'b0));
        last_s = s8;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (!done8) chk("b2b_s_hold", s8, last_s);
            end while (!done8 && k < 40);
            chk("b2b_done", done8, 1);
            if (q8.size() > 0) chk("b2b_result", {ovf8, cout8, s8}, q8.pop_front());
            if (i > 0) chk("b2b_period", k, 10);
            last_s = s8;
            if (i < 3) begin
                a8 = ta[i+1]; b8 = tb[i+1];
                q8.push_back(model8(ta[i+1], tb[i+1], 1'b0));
            end else start8 = 1'b0;
        end

        // reset mid-operation
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_outputs", {busy8, done8, cout8, ovf8, s8}, 0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        chk("midrst_quiet", ndone, 0);
        op8("after_rst_1_1", 8'h01, 8'h01, 1'b0);
        chk("after_rst_s", s8, 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
